// File: rtl/serial_byte_tx.sv
// Parallel-to-serial framer: start bit, DATA_W data bits (LSB- or MSB-first),
// optional even parity and STOP_BITS stop bits, each bit held CLKS_PER_BIT clocks.
//
//  state    | meaning
//  S_IDLE   | line high, accepting a word when in_ready is set
//  S_START  | driving the start bit (0)
//  S_DATA   | driving data bits out of the shift register
//  S_PARITY | driving the even-parity bit
//  S_STOP   | driving stop bit(s) (1)
module serial_byte_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state, state_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [BIT_W-1:0]   bit_cnt, bit_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic               dir_reg, dir_next;
    logic               parity_reg, parity_next;
    logic               transfer;
    logic               bit_end;
    logic               frame_end;
    logic               tx_level;

    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        dir_next    = dir_reg;
        parity_next = parity_reg;
        frame_end   = 1'b0;
        tx_level    = 1'b1;
        transfer    = in_valid & in_ready;
        bit_end     = (baud_cnt == BAUD_LAST);

        case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_next  = S_START;
                    baud_next   = '0;
                    bit_next    = '0;
                    shift_next  = in_data;
                    dir_next    = in_dir;
                    parity_next = ^in_data;
                end
            end

            S_START: begin
                tx_level = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            S_DATA: begin
                // The shift direction follows the captured bit order, so the
                // outgoing bit always sits at one fixed end of the register.
                tx_level = dir_reg ? shift_reg[DATA_W-1] : shift_reg[0];
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = dir_reg ? (shift_reg << 1) : (shift_reg >> 1);
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            S_PARITY: begin
                tx_level = parity_reg;
                if (bit_end) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            S_STOP: begin
                tx_level = 1'b1;
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        state_next  = S_IDLE;
                        frame_end   = 1'b1;
                        bit_next    = '0;
                        shift_next  = '0;
                        dir_next    = 1'b0;
                        parity_next = 1'b0;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the current state, so the line lags the
    // state register by one clock; frame_end lets busy fall and done rise on
    // the same edge that the state returns to idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            dir_reg    <= 1'b0;
            parity_reg <= 1'b0;
            tx_out     <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            dir_reg    <= dir_next;
            parity_reg <= parity_next;
            tx_out     <= tx_level;
            in_ready   <= (state_next == S_IDLE);
            busy       <= (state != S_IDLE) && !frame_end;
            done       <= frame_end;
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx: two instances (parity + 1 stop, no parity + 2 stop)
// share stimulus; each has its own expected-frame queue and monitor.
module tb_serial_byte_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [31:0] lv;
        int          nbits;
        int          xfer;
        bit          b2b;
    } frame_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_dir;
    logic       in_valid;
    wire  [1:0] rdy_w;
    wire  [1:0] tx_w;
    wire  [1:0] busy_w;
    wire  [1:0] done_w;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     last_done [2];
    bit     b2b_mode = 1'b0;
    frame_t q0[$];
    frame_t q1[$];

    serial_byte_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
        .in_ready(rdy_w[0]), .tx_out(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    serial_byte_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
        .in_ready(rdy_w[1]), .tx_out(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int d, input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d want %0d (cycle %0d)", name, d, got, want, cyc);
        end
    endtask

    // Reference frame: list of line levels, one per bit period.
    function automatic frame_t model(input logic [7:0] data, input logic dir,
                                     input int pe, input int sb, input int xfer);
        frame_t f;
        int     n;
        f.lv = '1;
        n = 0;
        f.lv[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f.lv[n] = dir ? data[7-i] : data[i];
            n++;
        end
        if (pe != 0) begin
            f.lv[n] = (($countones(data) % 2) == 1);
            n++;
        end
        n += sb;
        f.nbits = n;
        f.xfer  = xfer;
        f.b2b   = b2b_mode;
        return f;
    endfunction

    // Handshake seen before an edge means the transfer happens on that edge.
    always @(negedge clk) begin
        if (reset && in_valid && rdy_w[0]) q0.push_back(model(in_data, in_dir, 1, 1, cyc + 1));
        if (reset && in_valid && rdy_w[1]) q1.push_back(model(in_data, in_dir, 0, 2, cyc + 1));
    end

    task automatic monitor(input int d);
        frame_t      e;
        logic        prev;
        int          len, s, bi, nb, qsz;
        int          busy_bad, done_bad, rdy_bad;
        bit          aborted;
        logic [31:0] bgot;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b1;
                continue;
            end
            if (!(tx_w[d] == 1'b0 && prev == 1'b1)) begin
                check(d, "idle_busy_done", int'({busy_w[d], done_w[d]}), 0);
                prev = tx_w[d];
                continue;
            end
            s   = cyc;
            qsz = (d == 0) ? q0.size() : q1.size();
            check(d, "frame_expected", int'(qsz != 0), 1);
            if (qsz == 0) begin
                prev = 1'b0;
                continue;
            end
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            len = e.nbits * CPB;
            check(d, "start_latency", s, e.xfer + 1);
            if (e.b2b) check(d, "b2b_gap", s, last_done[d] + 2);
            busy_bad = 0;
            done_bad = 0;
            rdy_bad  = 0;
            aborted  = 1'b0;
            bgot     = '0;
            nb       = 0;
            for (int j = 1; j <= len; j++) begin
                if (j > 1) @(negedge clk);
                bi = (j - 1) / CPB;
                if (((j - 1) % CPB) == 0 || tx_w[d] !== e.lv[bi]) bgot[bi] = tx_w[d];
                if (busy_w[d] !== (j < len))  busy_bad++;
                if (done_w[d] !== (j == len)) done_bad++;
                if (rdy_w[d] !== (j == len))  rdy_bad++;
                nb = bi + 1;
                if (!reset) begin
                    aborted = 1'b1;
                    break;
                end
            end
            for (int i = 0; i < nb; i++) check(d, "frame_bit", int'(bgot[i]), int'(e.lv[i]));
            check(d, "busy_profile", busy_bad, 0);
            check(d, "done_profile", done_bad, 0);
            check(d, "ready_profile", rdy_bad, 0);
            if (aborted) begin
                @(negedge clk);
                check(d, "reset_abort", int'({tx_w[d], busy_w[d], done_w[d], rdy_w[d]}), 8);
            end else begin
                last_done[d] = cyc;
            end
            prev = 1'b1;
        end
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send(input logic [7:0] data, input logic dir);
        bit acc;
        acc = 1'b0;
        in_data  = data;
        in_dir   = dir;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rdy_w[0]) begin
                acc = 1'b1;
                break;
            end
        end
        check(0, "accept_wait", int'(acc), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_dir   = 1'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_w[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check(0, "done_wait", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit waited;
        last_done[0] = -100;
        last_done[1] = -100;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_dir   = 1'b0;

        // reset held with in_valid asserted
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check(d, "reset_hold", int'({tx_w[d], rdy_w[d], busy_w[d], done_w[d]}), 8);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check(d, "first_release", int'({tx_w[d], rdy_w[d], busy_w[d], done_w[d]}), 12);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done();
        idle(3);

        // directed frames
        send(8'hA5, 1'b0); wait_done(); idle(2);
        send(8'hA5, 1'b1); wait_done(); idle(1);
        send(8'h01, 1'b1); wait_done(); idle(2);

        // back-to-back with in_valid held
        send(8'h3C, 1'b0);
        b2b_mode = 1'b1;
        send(8'hC3, 1'b0);
        b2b_mode = 1'b0;
        wait_done();
        idle(3);

        // word offered while busy must be ignored
        send(8'h96, 1'b1);
        idle(10);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        idle(1);
        in_valid = 1'b0;
        wait_done();
        idle(50);

        // reset at cycle 17 of a frame
        send(8'h5B, 1'b1);
        idle(16);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check(d, "ready_after_abort", int'({tx_w[d], rdy_w[d], busy_w[d]}), 6);
        @(posedge clk);
        #1;
        idle(60);

        // randomized frames, sometimes back-to-back
        waited = 1'b1;
        for (int r = 0; r < 14; r++) begin
            b2b_mode = !waited;
            send(8'($urandom), 1'($urandom));
            b2b_mode = 1'b0;
            if ($urandom_range(0, 2) == 0 && r != 13) begin
                waited = 1'b0;
            end else begin
                wait_done();
                idle($urandom_range(0, 3));
                waited = 1'b1;
            end
        end
        idle(20);

        check(0, "pending_frames", q0.size(), 0);
        check(1, "pending_frames", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
